// File: rtl/rom_word_arbiter.sv
// Two-requester round-robin arbiter in front of a 16-word memory.
// A fetch port (read only) and a loader port (read/write) share one timed access path.

module decoder4to16 (
  input  logic [3:0]  addr,
  output logic [15:0] onehot
);
  assign onehot = 16'h0001 << addr;
endmodule

// state  | meaning
// IDLE   | no access in flight, requests sampled each edge
// ACCESS | word selected, mem_oe/mem_we driven, cnt counts down to 0
// DONE   | one-cycle ack to the granted requester
module rom_word_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        fetch_req,
  input  logic [3:0]  fetch_addr,
  output logic        fetch_ack,
  input  logic        load_req,
  input  logic [3:0]  load_addr,
  input  logic        load_we,
  input  logic [7:0]  load_wdata,
  output logic        load_ack,
  output logic [15:0] word_sel,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  rom_data,
  output logic [7:0]  rd_data,
  output logic        busy
);

  // A parameter of 0 is treated as a single-cycle access.
  localparam logic [3:0] CNT_LOAD = (ACCESS_CYCLES <= 1) ? 4'd0 : 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        last_grant;   // 1 = loader was granted last
  logic        gnt_load;
  logic [3:0]  lat_addr;
  logic        lat_op;
  logic [7:0]  lat_data;
  logic        take;
  logic        pick_load;
  logic [15:0] dec_sel;

  decoder4to16 u_dec (
    .addr   (lat_addr),
    .onehot (dec_sel)
  );

  always_comb begin
    next_state = IDLE;
    take       = 1'b0;
    pick_load  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req && load_req) begin
          take      = 1'b1;
          pick_load = ~last_grant;
        end else if (fetch_req) begin
          take      = 1'b1;
          pick_load = 1'b0;
        end else if (load_req) begin
          take      = 1'b1;
          pick_load = 1'b1;
        end
        next_state = take ? ACCESS : IDLE;
      end
      ACCESS:  next_state = (cnt == 4'd0) ? DONE : ACCESS;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      gnt_load   <= 1'b0;
      lat_addr   <= 4'd0;
      lat_op     <= 1'b0;
      lat_data   <= 8'd0;
      rd_data    <= 8'd0;
    end else begin
      state <= next_state;
      if (take) begin
        gnt_load   <= pick_load;
        last_grant <= pick_load;
        lat_addr   <= pick_load ? load_addr : fetch_addr;
        lat_op     <= pick_load & load_we;
        lat_data   <= pick_load ? load_wdata : 8'd0;
        cnt        <= CNT_LOAD;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && cnt == 4'd0 && !lat_op)
        rd_data <= rom_data;
    end
  end

  // Outputs decode from registered state only, so reset clears them immediately.
  always_comb begin
    word_sel  = 16'h0000;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    fetch_ack = 1'b0;
    load_ack  = 1'b0;
    busy      = (state != IDLE);
    if (state == ACCESS) begin
      word_sel  = dec_sel;
      mem_oe    = ~lat_op;
      mem_we    = lat_op;
      mem_wdata = lat_op ? lat_data : 8'h00;
    end
    if (state == DONE) begin
      fetch_ack = ~gnt_load;
      load_ack  = gnt_load;
    end
  end

endmodule

// File: tb/tb_rom_word_arbiter.sv
// Directed bench for rom_word_arbiter: default timing instance plus ACCESS_CYCLES=0 and 15
// instances sharing the same stimulus.

module tb_rom_word_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        fetch_req, load_req, load_we;
  logic [3:0]  fetch_addr, load_addr;
  logic [7:0]  load_wdata, rom_data;

  logic        fetch_ack, load_ack, mem_oe, mem_we, busy;
  logic [15:0] word_sel;
  logic [7:0]  mem_wdata, rd_data;

  logic        d0_fetch_ack, d0_load_ack, d0_mem_oe, d0_mem_we, d0_busy;
  logic [15:0] d0_word_sel;
  logic [7:0]  d0_mem_wdata, d0_rd_data;

  logic        d15_fetch_ack, d15_load_ack, d15_mem_oe, d15_mem_we, d15_busy;
  logic [15:0] d15_word_sel;
  logic [7:0]  d15_mem_wdata, d15_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rom_word_arbiter dut (
    .clk(clk), .clr_n(clr_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .load_req(load_req), .load_addr(load_addr), .load_we(load_we),
    .load_wdata(load_wdata), .load_ack(load_ack),
    .word_sel(word_sel), .mem_oe(mem_oe), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .rom_data(rom_data), .rd_data(rd_data), .busy(busy)
  );

  rom_word_arbiter #(.ACCESS_CYCLES(0)) dut0 (
    .clk(clk), .clr_n(clr_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(d0_fetch_ack),
    .load_req(load_req), .load_addr(load_addr), .load_we(load_we),
    .load_wdata(load_wdata), .load_ack(d0_load_ack),
    .word_sel(d0_word_sel), .mem_oe(d0_mem_oe), .mem_we(d0_mem_we), .mem_wdata(d0_mem_wdata),
    .rom_data(rom_data), .rd_data(d0_rd_data), .busy(d0_busy)
  );

  rom_word_arbiter #(.ACCESS_CYCLES(15)) dut15 (
    .clk(clk), .clr_n(clr_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(d15_fetch_ack),
    .load_req(load_req), .load_addr(load_addr), .load_we(load_we),
    .load_wdata(load_wdata), .load_ack(d15_load_ack),
    .word_sel(d15_word_sel), .mem_oe(d15_mem_oe), .mem_we(d15_mem_we), .mem_wdata(d15_mem_wdata),
    .rom_data(rom_data), .rd_data(d15_rd_data), .busy(d15_busy)
  );

  task automatic apply_reset();
    fetch_req  = 1'b0;
    load_req   = 1'b0;
    load_we    = 1'b0;
    fetch_addr = 4'h0;
    load_addr  = 4'h0;
    load_wdata = 8'h00;
    clr_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    fetch_req = 1'b1;
    fetch_addr = 4'h2;
    @(posedge clk); #1;
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({word_sel, mem_oe, mem_we, mem_wdata, fetch_ack, load_ack, busy, rd_data} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ws=%h oe=%b we=%b wd=%h fa=%b la=%b busy=%b rd=%h, expected all 0",
               word_sel, mem_oe, mem_we, mem_wdata, fetch_ack, load_ack, busy, rd_data);
    end
    n_checks++;
    if ({d15_word_sel, d15_busy, d0_word_sel, d0_busy} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_param: got ws15=%h b15=%b ws0=%h b0=%b, expected 0",
               d15_word_sel, d15_busy, d0_word_sel, d0_busy);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_single_fetch();
    apply_reset();
    rom_data   = 8'h3C;
    fetch_addr = 4'hA;
    fetch_req  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (c <= 2) begin
        if (word_sel !== 16'h0400 || mem_oe !== 1'b1 || mem_we !== 1'b0 || fetch_ack !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_access_c%0d: got ws=%h oe=%b we=%b ack=%b busy=%b, expected ws=0400 oe=1 we=0 ack=0 busy=1",
                   c, word_sel, mem_oe, mem_we, fetch_ack, busy);
        end
      end else begin
        if (fetch_ack !== 1'b1 || load_ack !== 1'b0 || word_sel !== 16'h0 || mem_oe !== 1'b0 || rd_data !== 8'h3C) begin
          n_fail++;
          $display("FAIL single_done: got fa=%b la=%b ws=%h oe=%b rd=%h, expected fa=1 la=0 ws=0 oe=0 rd=3c",
                   fetch_ack, load_ack, word_sel, mem_oe, rd_data);
        end
      end
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || fetch_ack !== 1'b0 || rd_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b fa=%b rd=%h, expected busy=0 fa=0 rd=3c", busy, fetch_ack, rd_data);
    end
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    rom_data   = 8'h99;
    fetch_addr = 4'h1;
    load_addr  = 4'h2;
    load_we    = 1'b1;
    load_wdata = 8'h55;
    fetch_req  = 1'b1;
    load_req   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      case (c)
        1, 2: begin
          n_checks++;
          if (word_sel !== 16'h0002 || mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL tie_fetch_access_c%0d: got ws=%h oe=%b we=%b wd=%h, expected ws=0002 oe=1 we=0 wd=00",
                     c, word_sel, mem_oe, mem_we, mem_wdata);
          end
        end
        3: begin
          n_checks++;
          if (fetch_ack !== 1'b1 || load_ack !== 1'b0 || rd_data !== 8'h99) begin
            n_fail++;
            $display("FAIL tie_fetch_ack: got fa=%b la=%b rd=%h, expected fa=1 la=0 rd=99", fetch_ack, load_ack, rd_data);
          end
          fetch_req = 1'b0;
          rom_data  = 8'h11;
        end
        4: begin
          n_checks++;
          if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_gap: got busy=%b, expected 0", busy);
          end
        end
        5, 6: begin
          n_checks++;
          if (word_sel !== 16'h0004 || mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_wdata !== 8'h55) begin
            n_fail++;
            $display("FAIL tie_load_access_c%0d: got ws=%h we=%b oe=%b wd=%h, expected ws=0004 we=1 oe=0 wd=55",
                     c, word_sel, mem_we, mem_oe, mem_wdata);
          end
        end
        7: begin
          n_checks++;
          if (load_ack !== 1'b1 || fetch_ack !== 1'b0 || rd_data !== 8'h99) begin
            n_fail++;
            $display("FAIL tie_load_ack: got la=%b fa=%b rd=%h, expected la=1 fa=0 rd=99", load_ack, fetch_ack, rd_data);
          end
          load_req = 1'b0;
        end
        default: begin
          n_checks++;
          if (busy !== 1'b0 || rd_data !== 8'h99) begin
            n_fail++;
            $display("FAIL tie_end: got busy=%b rd=%h, expected busy=0 rd=99", busy, rd_data);
          end
        end
      endcase
    end
  endtask

  task automatic test_round_robin();
    logic order [4];
    int   n_acks = 0;
    int   gaps = 0;
    int   both = 0;
    apply_reset();
    load_we    = 1'b0;
    fetch_addr = 4'h6;
    load_addr  = 4'h5;
    fetch_req  = 1'b1;
    load_req   = 1'b1;
    for (int i = 0; i < 4; i++) order[i] = 1'bx;
    for (int c = 0; c < 40 && n_acks < 4; c++) begin
      @(posedge clk); #1;
      if (fetch_ack && load_ack) both++;
      if (fetch_ack || load_ack) begin
        order[n_acks] = load_ack;
        n_acks++;
      end else if (!busy) begin
        gaps++;
      end
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    n_checks++;
    if (n_acks != 4) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d acks, expected 4", n_acks);
    end
    n_checks++;
    if (order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0 || order[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_order: got %b%b%b%b (1=load), expected 0101", order[0], order[1], order[2], order[3]);
    end
    n_checks++;
    if (gaps != 3) begin
      n_fail++;
      $display("FAIL rr_idle_gaps: got %0d idle cycles, expected 3", gaps);
    end
    n_checks++;
    if (both != 0) begin
      n_fail++;
      $display("FAIL rr_dual_ack: got %0d cycles with both acks, expected 0", both);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    apply_reset();
    rom_data   = 8'hAA;
    fetch_addr = 4'h3;
    fetch_req  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (word_sel !== 16'h0008 || mem_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got ws=%h oe=%b, expected ws=0008 oe=1", word_sel, mem_oe);
    end
    #1 clr_n = 1'b0;
    #1;
    n_checks++;
    if (word_sel !== 16'h0 || mem_oe !== 1'b0 || busy !== 1'b0 || fetch_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_immediate: got ws=%h oe=%b busy=%b fa=%b, expected all 0", word_sel, mem_oe, busy, fetch_ack);
    end
    fetch_req = 1'b0;
    @(posedge clk); #1;
    if (fetch_ack || load_ack) acks++;
    @(negedge clk);
    clr_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (fetch_ack || load_ack || busy) acks++;
    end
    n_checks++;
    if (acks != 0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_after: got %0d ack/busy cycles rd=%h, expected 0 and rd=00", acks, rd_data);
    end
    @(negedge clk);
    fetch_addr = 4'h7;
    fetch_req  = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (word_sel !== 16'h0080 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_release_grant: got ws=%h busy=%b, expected ws=0080 busy=1", word_sel, busy);
    end
    repeat (2) @(posedge clk);
    #1 fetch_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_access_cycles();
    int n2 = 0, n0 = 0, n15 = 0, bad = 0, a2 = 0, a0 = 0, a15 = 0;
    apply_reset();
    rom_data   = 8'h5A;
    fetch_addr = 4'hF;
    fetch_req  = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        fetch_req  = 1'b0;
        fetch_addr = 4'h3;
      end
      if (word_sel == 16'h8000) n2++; else if (word_sel != 16'h0) bad++;
      if (d0_word_sel == 16'h8000) n0++; else if (d0_word_sel != 16'h0) bad++;
      if (d15_word_sel == 16'h8000) n15++; else if (d15_word_sel != 16'h0) bad++;
      if (fetch_ack) a2++;
      if (d0_fetch_ack) a0++;
      if (d15_fetch_ack) a15++;
    end
    n_checks++;
    if (n0 != 1) begin
      n_fail++;
      $display("FAIL ac0_cycles: got %0d select cycles, expected 1", n0);
    end
    n_checks++;
    if (n15 != 15) begin
      n_fail++;
      $display("FAIL ac15_cycles: got %0d select cycles, expected 15", n15);
    end
    n_checks++;
    if (n2 != 2) begin
      n_fail++;
      $display("FAIL ac2_cycles: got %0d select cycles, expected 2", n2);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL addr_change_ignored: got %0d cycles with other word selected, expected 0", bad);
    end
    n_checks++;
    if (a0 != 1 || a2 != 1 || a15 != 1) begin
      n_fail++;
      $display("FAIL dropped_req_acks: got acks ac0=%0d ac2=%0d ac15=%0d, expected 1 each", a0, a2, a15);
    end
    n_checks++;
    if (d15_rd_data !== 8'h5A || d0_rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL param_rd_data: got rd0=%h rd15=%h, expected 5a", d0_rd_data, d15_rd_data);
    end
  endtask

  initial begin
    clr_n      = 1'b0;
    rom_data   = 8'h00;
    fetch_req  = 1'b0;
    load_req   = 1'b0;
    load_we    = 1'b0;
    fetch_addr = 4'h0;
    load_addr  = 4'h0;
    load_wdata = 8'h00;
    test_reset();
    test_single_fetch();
    test_tie_after_reset();
    test_round_robin();
    test_reset_mid_access();
    test_access_cycles();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_word_arbiter.md
ROM_WORD_ARBITER -- requirements
Module: rom_word_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2: cycles the memory word stays selected per access; legal 1..15, and 0 SHALL behave as 1.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr_n  input  1  reset, asynchronous and active-low.
REQ-004 fetch_req  input  1  fetch requester read request; level, held until fetch_ack.
REQ-005 fetch_addr  input  4  fetch word address.
REQ-006 fetch_ack  output  1  one-cycle pulse: fetch access complete, rd_data valid.
REQ-007 load_req  input  1  loader request; level, held until load_ack.
REQ-008 load_addr  input  4  loader word address.
REQ-009 load_we  input  1  loader op: 1 = write, 0 = read.
REQ-010 load_wdata  input  8  loader write data.
REQ-011 load_ack  output  1  one-cycle pulse: loader access complete.
REQ-012 word_sel  output  16  one-hot memory word enable, produced by an internal decoder4to16 instance driven by the latched address.
REQ-013 mem_oe  output  1  memory read enable.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_wdata  output  8  write data to memory.
REQ-016 rom_data  input  8  memory read data.
REQ-017 rd_data  output  8  captured read data, held until the next read completes.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and DONE, encoded in 2 bits; the unused encoding SHALL go to IDLE.
REQ-020 IDLE: with no request, the FSM stays in IDLE and word_sel, mem_oe, mem_we, fetch_ack and load_ack are 0.
REQ-021 IDLE with one request: grant that requester; latch its address, op (fetch is always read) and write data; next state ACCESS; load cnt = ACCESS_CYCLES-1.
REQ-022 IDLE with both requests: grant the requester not granted last (round-robin via a 1-bit last_grant register); last_grant updates at grant.
REQ-023 ACCESS: word_sel = decode(latched address), exactly one bit set; mem_oe = ~op, mem_we = op; mem_wdata = latched data for writes, else 0.
REQ-024 ACCESS: the FSM stays in ACCESS while cnt != 0 and decrements cnt each cycle; when cnt == 0 it captures rom_data into rd_data (reads only) and moves to DONE.
REQ-025 DONE lasts exactly one cycle: the granted requester's ack = 1, word_sel/mem_oe/mem_we = 0, next state IDLE.
REQ-026 Latency: a request sampled in IDLE at edge N gives ACCESS for edges N+1..N+ACCESS_CYCLES and an ack high in cycle N+ACCESS_CYCLES+1; with the default, an access takes 4 cycles from grant to return to IDLE.
REQ-027 Requesters SHALL drop req in the cycle after ack; a req still high when the FSM is back in IDLE is a new request.
REQ-028 Address, op and data changes after grant SHALL be ignored until the next grant.
REQ-029 A req that drops mid-access SHALL NOT abort: the access completes and the ack still pulses.
REQ-030 fetch_ack and load_ack SHALL never be high in the same cycle.
REQ-031 Write accesses SHALL leave rd_data unchanged.
REQ-032 Address 15 SHALL select word_sel[15] with no wrap or aliasing.

Reset
REQ-033 clr_n low SHALL immediately force: state IDLE, cnt 0, last_grant = load (so fetch wins the first tie), rd_data 0, latched address/op/data 0, all outputs 0.
REQ-034 Reset asserted mid-ACCESS SHALL abort the access, with no ack either during reset or after release.
REQ-035 After clr_n rises, the first rising edge SHALL sample requests normally.

Verification
REQ-036 Single fetch: ACCESS_CYCLES=2, fetch_addr=4'hA, rom_data=8'h3C -> word_sel=16'h0400 for 2 cycles with mem_oe=1, then fetch_ack pulse, rd_data=8'h3C.
REQ-037 Simultaneous requests after reset: fetch addr 1, load write addr 2 data 8'h55 -> fetch served first (word_sel=16'h0002), then load (word_sel=16'h0004, mem_we=1, mem_wdata=8'h55); acks in that order.
REQ-038 Both requests held continuously for 4 grants -> grant order fetch, load, fetch, load; busy low for exactly one cycle between accesses.
REQ-039 Reset mid-access: clr_n low during the 2nd ACCESS cycle -> all outputs 0 the same cycle, no ack, and rd_data=0 after release.
REQ-040 ACCESS_CYCLES=0 and 15, fetch_addr=4'hF -> word_sel=16'h8000 held for 1 and 15 cycles respectively; fetch_addr changes during ACCESS do not change word_sel.
